// File: rtl/conv_wreg_dbuf.sv
// conv_wreg_dbuf: double-buffered convolution weight bank.
// A shadow bank is loaded by shifting while the active bank stays stable; a guarded swap copies it over.
module conv_wreg_dbuf #(
    parameter int DWIDTH = 16,
    parameter int FSIZE  = 5,
    parameter int CWIDTH = 5
) (
    input  logic                            clk,
    input  logic                            xrst,
    input  logic                            load_clear,
    input  logic                            wreg_we,
    input  logic signed [DWIDTH-1:0]        read_data,
    input  logic                            swap,
    output logic [FSIZE*FSIZE*DWIDTH-1:0]   weight,
    output logic                            active_valid,
    output logic                            shadow_full,
    output logic                            load_done,
    output logic [CWIDTH-1:0]               load_count,
    output logic                            wr_ovf
);
    localparam int N = FSIZE * FSIZE;
    localparam logic [CWIDTH-1:0] NC = CWIDTH'(N);
    logic [N-1:0][DWIDTH-1:0] shadow_q, shadow_d, active_q, active_d;
    logic [CWIDTH-1:0] cnt_q, cnt_d;
    logic full_q, full_d, valid_q, valid_d, done_q, done_d, wr_acc, sw_acc;
    always_comb begin
        wr_acc   = wreg_we & ~full_q & ~load_clear;
        sw_acc   = swap & full_q & ~load_clear;
        shadow_d = wr_acc ? {read_data, shadow_q[N-1:1]} : shadow_q;
        active_d = sw_acc ? shadow_q : active_q;
        cnt_d    = (load_clear | sw_acc) ? '0 : cnt_q + CWIDTH'(wr_acc);
        full_d   = cnt_d == NC;
        done_d   = wr_acc & (cnt_q == NC - 1'b1);
        valid_d  = valid_q | sw_acc;
        // a write is dropped whenever the shadow bank was full at cycle start, including on the swap cycle
        wr_ovf   = xrst & wreg_we & full_q & ~load_clear;
    end
    always_ff @(posedge clk) begin
        if (!xrst) begin
            shadow_q <= '0;
            active_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end
    assign weight       = active_q;
    assign active_valid = valid_q;
    assign shadow_full  = full_q;
    assign load_done    = done_q;
    assign load_count   = cnt_q;
endmodule

// File: tb/tb_conv_wreg_dbuf.sv
// tb_conv_wreg_dbuf: directed self-checking bench for conv_wreg_dbuf.
module tb_conv_wreg_dbuf;
    logic clk = 1'b0, xrst = 1'b0, load_clear = 1'b0, wreg_we = 1'b0, swap = 1'b0;
    logic signed [15:0] read_data = '0;
    logic [399:0] weight;
    logic active_valid, shadow_full, load_done, wr_ovf, ovf_seen;
    logic [4:0] load_count;
    int checks = 0, errors = 0;

    conv_wreg_dbuf #(.DWIDTH(16), .FSIZE(5), .CWIDTH(5)) dut (
        .clk(clk), .xrst(xrst), .load_clear(load_clear), .wreg_we(wreg_we),
        .read_data(read_data), .swap(swap), .weight(weight),
        .active_valid(active_valid), .shadow_full(shadow_full), .load_done(load_done),
        .load_count(load_count), .wr_ovf(wr_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] tap(input int k);
        return weight[k*16 +: 16];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // wr_ovf is combinational, so it is captured mid-cycle while the inputs are still applied
    task automatic cyc(input logic we, input logic [15:0] d, input logic sw, input logic clr);
        wreg_we = we; read_data = d; swap = sw; load_clear = clr;
        @(negedge clk);
        ovf_seen = wr_ovf;
        @(posedge clk);
        #1;
        wreg_we = 1'b0; swap = 1'b0; load_clear = 1'b0;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) cyc(1'b1, 16'(base + i), 1'b0, 1'b0);
    endtask

    initial begin
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("rst_weight0", {31'b0, weight == '0}, 1);
        chk("rst_valid", active_valid, 0);
        chk("rst_full", shadow_full, 0);
        chk("rst_done", load_done, 0);
        chk("rst_count", load_count, 0);
        chk("rst_ovf", ovf_seen, 0);
        xrst = 1'b1;

        load(24, 1);
        chk("t1_count24", load_count, 24);
        chk("t1_done_early", load_done, 0);
        chk("t1_full_early", shadow_full, 0);
        load(1, 25);
        chk("t1_done", load_done, 1);
        chk("t1_count", load_count, 25);
        chk("t1_full", shadow_full, 1);
        chk("t1_weight0", {31'b0, weight == '0}, 1);
        chk("t1_valid", active_valid, 0);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t1_done_once", load_done, 0);

        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t2_tap0", tap(0), 1);
        chk("t2_tap12", tap(12), 13);
        chk("t2_tap24", tap(24), 25);
        chk("t2_valid", active_valid, 1);
        chk("t2_count", load_count, 0);
        chk("t2_full", shadow_full, 0);

        load(25, -100);
        chk("t3_hold_tap0", tap(0), 1);
        chk("t3_hold_tap24", tap(24), 25);
        chk("t3_full", shadow_full, 1);
        cyc(1'b1, 16'h7FFF, 1'b0, 1'b0);
        chk("t3_ovf", ovf_seen, 1);
        chk("t3_ovf_count", load_count, 25);
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
        chk("t3_ovf_once", ovf_seen, 0);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t3_tap0", tap(0), 16'hFF9C);
        chk("t3_tap24", tap(24), 16'hFFB4);

        load(10, 500);
        chk("t4_count10", load_count, 10);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t4_noswap_tap0", tap(0), 16'hFF9C);
        chk("t4_noswap_count", load_count, 10);
        chk("t4_noswap_valid", active_valid, 1);
        cyc(1'b1, 16'h1234, 1'b0, 1'b1);
        chk("t4_clr_ovf", ovf_seen, 0);
        chk("t4_clr_count", load_count, 0);
        load(25, 200);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t4_tap0", tap(0), 200);
        chk("t4_tap24", tap(24), 224);

        load(24, 300);
        cyc(1'b1, 16'd77, 1'b1, 1'b0);
        chk("t5_noswap_tap0", tap(0), 200);
        chk("t5_full", shadow_full, 1);
        chk("t5_done", load_done, 1);
        chk("t5_ovf_none", ovf_seen, 0);
        cyc(1'b1, 16'd55, 1'b1, 1'b0);
        chk("t5_swap_ovf", ovf_seen, 1);
        chk("t5_tap0", tap(0), 300);
        chk("t5_tap24", tap(24), 77);
        chk("t5_count", load_count, 0);

        load(13, 600);
        chk("t6_count13", load_count, 13);
        xrst = 1'b0;
        cyc(1'b1, 16'h1111, 1'b1, 1'b0);
        chk("t6_weight0", {31'b0, weight == '0}, 1);
        chk("t6_valid", active_valid, 0);
        chk("t6_count", load_count, 0);
        chk("t6_full", shadow_full, 0);
        chk("t6_done", load_done, 0);
        chk("t6_ovf", ovf_seen, 0);
        xrst = 1'b1;
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        chk("t6_swap_valid", active_valid, 0);
        chk("t6_swap_weight0", {31'b0, weight == '0}, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
